// File: rtl/adder_result_checker.sv
// Result checker for adder benches: stages each applied vector with its
// mismatch flag, retires it one edge later into the run counters, captures
// the first failing vector and reports a done/pass verdict after nvec vectors.
module adder_result_checker #(
    parameter int N     = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] nvec,
    input  logic             vec_valid,
    input  logic             cin,
    input  logic [N-1:0]     a,
    input  logic [N-1:0]     b,
    input  logic [N-1:0]     s_ref,
    input  logic [N-1:0]     s_duv,
    input  logic             cout_ref,
    input  logic             cout_duv,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [N-1:0]     first_err_a,
    output logic [N-1:0]     first_err_b,
    output logic             first_err_cin,
    output logic [N-1:0]     first_err_s,
    output logic             first_err_cout
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] tgt;
    logic [CNT_W-1:0] acc;       // vectors accepted into the stage this run
    logic [CNT_W-1:0] acc_inc;
    logic             arm;
    logic             accept;
    logic             mis;

    // Stage register: one vector waiting to be retired
    logic             stg_vld;
    logic             stg_mis;
    logic             stg_cin;
    logic             stg_cout;
    logic [N-1:0]     stg_a;
    logic [N-1:0]     stg_b;
    logic [N-1:0]     stg_s;

    // Run control decodes shared by the FSM and datapath
    always_comb begin
        arm     = start && (state == IDLE || state == DONE);
        accept  = (state == RUN) && vec_valid && (acc < tgt);
        acc_inc = acc + ONE;
        mis     = (s_ref != s_duv) || (cout_ref != cout_duv);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: FLUSH always holds exactly the last accepted entry,
    // so it lasts a single cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = (nvec == '0) ? DONE : RUN;
            RUN:        if (accept && acc_inc == tgt) state_nxt = FLUSH;
            FLUSH:      state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Verdict outputs follow the state so they line up with final counters
    always_comb begin
        busy = (state == RUN) || (state == FLUSH);
        done = (state == DONE);
        pass = done && (err_count == '0);
    end

    // Stage load, retirement into counters and first-failure capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tgt             <= '0;
            acc             <= '0;
            stg_vld         <= 1'b0;
            stg_mis         <= 1'b0;
            stg_cin         <= 1'b0;
            stg_cout        <= 1'b0;
            stg_a           <= '0;
            stg_b           <= '0;
            stg_s           <= '0;
            vec_count       <= '0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_idx   <= '0;
            first_err_a     <= '0;
            first_err_b     <= '0;
            first_err_cin   <= 1'b0;
            first_err_s     <= '0;
            first_err_cout  <= 1'b0;
        end else begin
            stg_vld <= accept;
            if (accept) begin
                stg_mis  <= mis;
                stg_a    <= a;
                stg_b    <= b;
                stg_cin  <= cin;
                stg_s    <= s_duv;
                stg_cout <= cout_duv;
            end
            if (arm) begin
                tgt             <= nvec;
                acc             <= '0;
                vec_count       <= '0;
                err_count       <= '0;
                first_err_valid <= 1'b0;
                first_err_idx   <= '0;
                first_err_a     <= '0;
                first_err_b     <= '0;
                first_err_cin   <= 1'b0;
                first_err_s     <= '0;
                first_err_cout  <= 1'b0;
            end else begin
                if (accept) acc <= acc_inc;
                if (stg_vld) begin
                    vec_count <= vec_count + ONE;
                    if (stg_mis && err_count != '1) err_count <= err_count + ONE;
                    if (stg_mis && !first_err_valid) begin
                        first_err_valid <= 1'b1;
                        first_err_idx   <= vec_count;
                        first_err_a     <= stg_a;
                        first_err_b     <= stg_b;
                        first_err_cin   <= stg_cin;
                        first_err_s     <= stg_s;
                        first_err_cout  <= stg_cout;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker: a 16-bit-counter instance for the
// main scenarios and a 4-bit-counter instance for the counter-limit scenario.
module tb_adder_result_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start4;
    logic [15:0] nvec;
    logic [3:0]  nvec4;
    logic        vec_valid, cin, cout_ref, cout_duv;
    logic [15:0] a, b, s_ref, s_duv;

    logic        busy, done, pass, fev, fcin, fcout;
    logic [15:0] vcnt, ecnt, fidx, fa, fb, fs;

    logic        busy4, done4, pass4, fev4, fcin4, fcout4;
    logic [3:0]  vcnt4, ecnt4, fidx4;
    logic [15:0] fa4, fb4, fs4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_result_checker #(.N(16), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .start(start), .nvec(nvec), .vec_valid(vec_valid),
        .cin(cin), .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv),
        .cout_ref(cout_ref), .cout_duv(cout_duv),
        .busy(busy), .done(done), .pass(pass), .vec_count(vcnt), .err_count(ecnt),
        .first_err_valid(fev), .first_err_idx(fidx), .first_err_a(fa),
        .first_err_b(fb), .first_err_cin(fcin), .first_err_s(fs),
        .first_err_cout(fcout)
    );

    adder_result_checker #(.N(16), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .nvec(nvec4), .vec_valid(vec_valid),
        .cin(cin), .a(a), .b(b), .s_ref(s_ref), .s_duv(s_duv),
        .cout_ref(cout_ref), .cout_duv(cout_duv),
        .busy(busy4), .done(done4), .pass(pass4), .vec_count(vcnt4), .err_count(ecnt4),
        .first_err_valid(fev4), .first_err_idx(fidx4), .first_err_a(fa4),
        .first_err_b(fb4), .first_err_cin(fcin4), .first_err_s(fs4),
        .first_err_cout(fcout4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one vector for one edge; xs/xc corrupt the DUV sum/carry
    task automatic apply(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                         input logic [15:0] xs, input logic xc);
        logic [16:0] sum;
        sum       = {1'b0, va} + {1'b0, vb} + {16'd0, vc};
        a         = va;
        b         = vb;
        cin       = vc;
        s_ref     = sum[15:0];
        cout_ref  = sum[16];
        s_duv     = sum[15:0] ^ xs;
        cout_duv  = sum[16] ^ xc;
        vec_valid = 1'b1;
        tick();
    endtask

    task automatic do_start(input logic [15:0] n);
        vec_valid = 1'b0;
        nvec      = n;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        logic [5:0] pat;
        rst = 1'b1; start = 1'b0; start4 = 1'b0; nvec = '0; nvec4 = '0;
        vec_valid = 1'b0; cin = 1'b0; a = '0; b = '0;
        s_ref = '0; s_duv = '0; cout_ref = 1'b0; cout_duv = 1'b0;
        #3;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass", pass, 0);
        chk("rst_vcnt", vcnt, 0);
        chk("rst_ecnt", ecnt, 0);
        chk("rst_fev",  fev,  0);
        @(negedge clk); rst = 1'b0;
        tick();

        // All-match run of 4
        do_start(4);
        chk("t1_busy", busy, 1);
        apply(16'h0000, 16'h0000, 0, 0, 0);
        apply(16'hFFFF, 16'h0001, 0, 0, 0);
        apply(16'h8000, 16'h8000, 1, 0, 0);
        apply(16'h1234, 16'h4321, 0, 0, 0);
        vec_valid = 1'b0;
        chk("t1_done_early", done, 0);
        chk("t1_vcnt_early", vcnt, 3);
        tick();
        chk("t1_done", done, 1);
        chk("t1_pass", pass, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_vcnt", vcnt, 4);
        chk("t1_ecnt", ecnt, 0);
        chk("t1_fev",  fev,  0);

        // Sum mismatch on index 1
        do_start(3);
        chk("t2_cleared", done, 0);
        apply(16'h0001, 16'h0002, 0, 0, 0);
        apply(16'hFFFF, 16'h0001, 0, 16'h0001, 0);
        apply(16'h0005, 16'h0006, 1, 0, 0);
        vec_valid = 1'b0;
        tick();
        chk("t2_done",  done,  1);
        chk("t2_pass",  pass,  0);
        chk("t2_vcnt",  vcnt,  3);
        chk("t2_ecnt",  ecnt,  1);
        chk("t2_fev",   fev,   1);
        chk("t2_fidx",  fidx,  1);
        chk("t2_fa",    fa,    16'hFFFF);
        chk("t2_fb",    fb,    16'h0001);
        chk("t2_fcin",  fcin,  0);
        chk("t2_fs",    fs,    16'h0001);
        chk("t2_fcout", fcout, 1);

        // Carry mismatches on indices 2 and 4; a start mid-run is ignored
        do_start(5);
        apply(16'h0010, 16'h0020, 0, 0, 0);
        apply(16'h0100, 16'h0200, 1, 0, 0);
        do_start(1);
        apply(16'h00FF, 16'h0001, 0, 0, 1);
        apply(16'h0003, 16'h0004, 0, 0, 0);
        apply(16'hF000, 16'h1000, 0, 0, 1);
        vec_valid = 1'b0;
        tick();
        chk("t3_done",  done,  1);
        chk("t3_vcnt",  vcnt,  5);
        chk("t3_ecnt",  ecnt,  2);
        chk("t3_fidx",  fidx,  2);
        chk("t3_fa",    fa,    16'h00FF);
        chk("t3_fs",    fs,    16'h0100);
        chk("t3_fcout", fcout, 1);

        // Gapped valid pattern, then extra vectors after the limit
        do_start(3);
        pat = 6'b101001;               // cycle 0 is bit 0
        for (int i = 0; i < 6; i++) begin
            if (pat[i]) apply(16'h0700 + 16'(i), 16'h0011, 0, 0, 0);
            else begin vec_valid = 1'b0; tick(); end
            if (i == 2) chk("t4_vcnt_mid", vcnt, 1);
        end
        chk("t4_done_early", done, 0);
        apply(16'h0001, 16'h0001, 0, 16'h0001, 0);
        chk("t4_done", done, 1);
        chk("t4_vcnt", vcnt, 3);
        apply(16'h0002, 16'h0002, 0, 16'h0001, 0);
        vec_valid = 1'b0;
        chk("t4_vcnt_hold", vcnt, 3);
        chk("t4_ecnt", ecnt, 0);
        chk("t4_pass", pass, 1);

        // Asynchronous reset mid-run, then an empty run
        do_start(10);
        apply(16'h0001, 16'h0001, 0, 16'h0004, 0);
        apply(16'h0002, 16'h0002, 0, 0, 0);
        vec_valid = 1'b0;
        tick();
        chk("t5_pre_vcnt", vcnt, 2);
        chk("t5_pre_fev",  fev,  1);
        #1 rst = 1'b1;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_vcnt", vcnt, 0);
        chk("t5_rst_ecnt", ecnt, 0);
        chk("t5_rst_fev",  fev,  0);
        chk("t5_rst_fa",   fa,   0);
        @(negedge clk); rst = 1'b0;
        tick();
        do_start(0);
        chk("t5_z_done", done, 1);
        chk("t5_z_pass", pass, 1);
        chk("t5_z_vcnt", vcnt, 0);
        chk("t5_z_busy", busy, 0);

        // 4-bit counters: 15 mismatching vectors
        nvec4 = 4'd15; start4 = 1'b1; tick(); start4 = 1'b0;
        for (int i = 0; i < 15; i++) apply(16'(i), 16'h0100, 0, 16'h8000, 0);
        vec_valid = 1'b0;
        tick();
        chk("t6_done", done4, 1);
        chk("t6_pass", pass4, 0);
        chk("t6_vcnt", vcnt4, 15);
        chk("t6_ecnt", ecnt4, 15);
        chk("t6_fidx", fidx4, 0);
        chk("t6_fs",   fs4,   16'h8100);
        tick();
        chk("t6_ecnt_hold", ecnt4, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/adder_result_checker.md
Name: adder_result_checker

Overview:
- Self-checking stage downstream of the adder DUV and the reference adder in the adder benches.
- Samples each applied vector (cin, a, b) together with the reference and DUV results.
- Counts the applied vectors and the mismatches, and captures the first failing vector.
- Reports done/pass after a programmed number of vectors, so the random or file-driven runs end with a single verdict instead of a log scan.

Parameters:
- N, 16, operand/sum width (matches adder n).
- CNT_W, 16, width of the vector, error and index counters.

Ports:
- clk  input  1  bench clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; arms a new run (accepted only in IDLE or DONE).
- nvec  input  CNT_W  number of vectors in the run; sampled on accepted start.
- vec_valid  input  1  current vector and results are valid this cycle.
- cin  input  1  applied carry-in.
- a, b  input  N  applied operands.
- s_ref, s_duv  input  N  reference / DUV sum.
- cout_ref, cout_duv  input  1  reference / DUV carry-out.
- busy  output  1  run in progress (RUN or FLUSH).
- done  output  1  run finished; held until next start.
- pass  output  1  done with err_count==0; 0 whenever done==0.
- vec_count  output  CNT_W  vectors compared in the current run.
- err_count  output  CNT_W  mismatching vectors; saturates at all-ones.
- first_err_valid  output  1  first-failure capture is populated.
- first_err_idx  output  CNT_W  0-based index of the first failing vector.
- first_err_a, first_err_b  output  N  operands of the first failure.
- first_err_cin  output  1  carry-in of the first failure.
- first_err_s, first_err_cout  output  N / 1  DUV results of the first failure.

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; stage register empty.
- States: IDLE, RUN, FLUSH, DONE.
- IDLE/DONE + start:
  - latch nvec into tgt;
  - clear vec_count, err_count, first_err_* and done;
  - go to RUN, or straight to DONE with pass=1 if nvec==0.
- Pipeline stage:
  - In RUN, a vector with vec_valid=1 is registered into the stage together with a mismatch flag, mis = (s_ref!=s_duv) | (cout_ref!=cout_duv).
  - A registered entry is retired on the next rising edge: vec_count+1; err_count+1 if mis (saturating).
  - If mis and first_err_valid==0: capture a, b, cin, s_duv, cout_duv, and first_err_idx=vec_count (pre-increment value); set first_err_valid.
  - Latency from vector to counters: 2 edges.
- Accept limit:
  - RUN accepts vectors only while accepted-count < tgt. The accepted count is internal and counts separately from vec_count.
  - When the tgt-th vector is accepted, go to FLUSH.
  - vec_valid in IDLE, FLUSH or DONE is ignored; no count changes.
- FLUSH: retires the last staged entry and then goes to DONE. done=1 and pass=(err_count==0) are valid in the same cycle that the final counters are valid.
- busy = (state==RUN)|(state==FLUSH).
- Counter behaviour:
  - vec_count never exceeds tgt.
  - err_count saturates at 2^CNT_W-1 and does not wrap.
- start in RUN/FLUSH is ignored.
- rst asserted mid-run: immediate return to IDLE with all outputs cleared; the partial run is lost.
- Holes in vec_valid: gaps of any length are allowed; the stage only retires valid entries.

Test Plan:
- nvec=4, vectors (a,b,cin) = (0x0000,0x0000,0), (0xFFFF,0x0001,0), (0x8000,0x8000,1), (0x1234,0x4321,0); DUV == ref -> after the 4th vector + 2 edges: done=1, pass=1, vec_count=4, err_count=0, first_err_valid=0.
- nvec=3, DUV s forced to 0x0001 on vector index 1 only (a=0xFFFF, b=0x0001, ref s=0x0000, cout=1) -> err_count=1, pass=0, first_err_idx=1, first_err_a=0xFFFF, first_err_s=0x0001, first_err_cout=1.
- nvec=5, carry-out mismatch on indices 2 and 4 -> err_count=2, first_err_idx=2; index 4 is not captured.
- nvec=3 with vec_valid pattern 1,0,0,1,0,1 and 2 extra valid vectors afterwards -> vec_count=3; the extra vectors are ignored; done asserts 2 edges after the 6th cycle.
- rst pulse asserted after 2 of nvec=10 vectors -> all outputs 0 immediately (asynchronous); a new start with nvec=0 -> DONE next edge with pass=1 and vec_count=0.
- CNT_W=4, nvec=15, all vectors mismatching -> err_count=15 (saturated, not wrapped), first_err_idx=0, pass=0.
